graph_window_ctrl: RTL and testbench

- Sequencer for the 32x32 binary image memory (word = column, bit = row; 5-bit read window at a row offset).
- Two jobs: load a full image from a serial pixel stream, then raster-scan every 5x5 window origin and emit each window as 25 bits over a valid/ready handshake.
- Sits between the input pixel source and the binarized convolution stage, and is the only master of the memory's en/RW/coladdr/rowaddr/data_in pins.

---
 rtl/graph_window_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_graph_window_ctrl.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_window_ctrl.sv
// ---------------------------------------------------------------------------
// graph_window_ctrl
//
// Sequencer for the 32x32 binary image memory (one word per column, one bit
// per row, 5-bit read slice starting at a row offset). It has two jobs:
//   * LOAD : write a full image taken from a serial pixel stream, with the
//            row as the fast-moving address field.
//   * SCAN : visit every 5x5 window origin in raster order. It fetches five
//            column slices through the memory's 1-cycle registered read port
//            and presents each window as 25 bits on a valid/ready handshake.
// This block is the only master of the memory's en/RW/coladdr/rowaddr/data_in
// pins.
//
// Optional build macro: GRAPH_WIN_ABORT_EN adds an 'abort' input. When abort
// is high in any busy state, the FSM returns to IDLE on the next edge and no
// done pulse is produced.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   abort                   (GRAPH_WIN_ABORT_EN only) cancel current job
//   start_load, start_scan  job start pulses, honoured only in IDLE
//   pix_data, pix_valid     serial pixel stream in
//   pix_ready               high while loading
//   mem_en, mem_rw          memory enable, 1=read / 0=write
//   mem_wdata               write bit
//   mem_col, mem_row        column (word) and row (bit) address
//   mem_rdata               5-bit read slice, one cycle after the read
//   win_valid, win_ready    window handshake
//   win_data                bit 5k+j = pixel(col0+k, row0+j)
//   win_col, win_row        window origin
//   win_last                final window of the scan (with win_valid)
//   busy                    FSM not in IDLE
//   done                    one-cycle pulse at the end of a load or scan
// ---------------------------------------------------------------------------
module graph_window_ctrl #(
  parameter int STRIDE  = 1,
  parameter int IMG_DIM = 32,
  parameter int WIN     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef GRAPH_WIN_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start_load,
  input  logic        start_scan,
  input  logic        pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_wdata,
  output logic [4:0]  mem_col,
  output logic [4:0]  mem_row,
  input  logic [4:0]  mem_rdata,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [24:0] win_data,
  output logic [4:0]  win_col,
  output logic [4:0]  win_row,
  output logic        win_last,
  output logic        busy,
  output logic        done
);

  // Largest legal origin is the last multiple of STRIDE that keeps the whole
  // window inside the image (27 for a 32-pixel side and a 5-pixel window).
  localparam int SPAN = IMG_DIM - WIN;
  localparam int LAST = SPAN - (SPAN % STRIDE);
  localparam logic [5:0] LAST6    = 6'(LAST);
  localparam logic [5:0] STRIDE6  = 6'(STRIDE);
  localparam logic [9:0] PIX_LAST = 10'(IMG_DIM * IMG_DIM - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RD   = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pix_idx_q, pix_idx_d;
  logic [2:0]  sub_q, sub_d;
  logic [4:0]  col0_q, col0_d;
  logic [4:0]  row0_q, row0_d;
  logic [24:0] win_q, win_d;

  // Candidate next origin, one bit wider so the overflow past LAST is visible.
  logic [5:0]  col_step;
  logic [5:0]  row_step;

  assign col_step = {1'b0, col0_q} + STRIDE6;
  assign row_step = {1'b0, row0_q} + STRIDE6;

  // State and counter registers. Reset clears everything, and because every
  // memory pin is decoded from the state, mem_en also drops asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pix_idx_q <= '0;
      sub_q     <= '0;
      col0_q    <= '0;
      row0_q    <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      sub_q     <= sub_d;
      col0_q    <= col0_d;
      row0_q    <= row0_d;
      win_q     <= win_d;
    end
  end

  // Next-state and memory-pin decode.
  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    sub_d     = sub_q;
    col0_d    = col0_q;
    row0_d    = row0_q;
    win_d     = win_q;
    pix_ready = 1'b0;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_wdata = 1'b0;
    mem_col   = '0;
    mem_row   = '0;
    win_valid = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        // A load request takes priority and swallows a coincident scan start.
        if (start_load) begin
          state_d   = LOAD;
          pix_idx_d = '0;
        end else if (start_scan) begin
          state_d = RD;
          col0_d  = '0;
          row0_d  = '0;
          sub_d   = '0;
        end
      end

      LOAD: begin
        // The pixel index splits as {column, row}, with the row moving fastest.
        pix_ready = 1'b1;
        mem_col   = pix_idx_q[9:5];
        mem_row   = pix_idx_q[4:0];
        if (pix_valid) begin
          mem_en    = 1'b1;
          mem_wdata = pix_data;
          if (pix_idx_q == PIX_LAST) begin
            state_d = FIN;
          end else begin
            pix_idx_d = pix_idx_q + 10'd1;
          end
        end
      end

      RD: begin
        // Reads are issued for sub-steps 0..4. Each slice returns one cycle
        // later, so sub-step k stores the column read at step k-1. The row
        // address stays on row0 for the whole fetch because the returned slice
        // is only meaningful while the row offset is held.
        mem_row = row0_q;
        if (sub_q < 3'd5) begin
          mem_en  = 1'b1;
          mem_rw  = 1'b1;
          mem_col = col0_q + 5'(sub_q);
        end
        case (sub_q)
          3'd1:    win_d[4:0]   = mem_rdata;
          3'd2:    win_d[9:5]   = mem_rdata;
          3'd3:    win_d[14:10] = mem_rdata;
          3'd4:    win_d[19:15] = mem_rdata;
          3'd5:    win_d[24:20] = mem_rdata;
          default: win_d        = win_q;
        endcase
        if (sub_q == 3'd5) begin
          state_d = OUT;
          sub_d   = '0;
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end

      OUT: begin
        // The window registers are not written here, so the presented window
        // stays stable for as long as the consumer stalls.
        win_valid = 1'b1;
        if (win_ready) begin
          if (col_step > LAST6) begin
            col0_d = '0;
            if (row_step > LAST6) begin
              state_d = FIN;
            end else begin
              row0_d  = row_step[4:0];
              state_d = RD;
            end
          end else begin
            col0_d  = col_step[4:0];
            state_d = RD;
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef GRAPH_WIN_ABORT_EN
    // Abort only redirects the next state. A write issued in this cycle
    // still completes, and no done pulse is produced.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done    = 1'b0;
    end
`endif
  end

  assign busy     = (state_q != IDLE);
  assign win_data = win_q;
  assign win_col  = col0_q;
  assign win_row  = row0_q;
  assign win_last = (state_q == OUT) && ({1'b0, col0_q} == LAST6) &&
                    ({1'b0, row0_q} == LAST6);

endmodule

// File: tb/tb_graph_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_graph_window_ctrl
//
// Directed bench for graph_window_ctrl. A behavioural 32x32 bit memory with a
// 1-cycle registered 5-bit read sits behind the STRIDE=1 instance. A second
// instance uses STRIDE=4 and reads from a preloaded copy of the same pattern.
// The image pattern is pixel(c,r) = c[0]^r[0], which comes from the load
// stream pix_data = i[5]^i[0].
// ---------------------------------------------------------------------------
module tb_graph_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      = 1'b0;
  logic        start_load = 1'b0;
  logic        start_scan = 1'b0;
  logic        pix_data   = 1'b0;
  logic        pix_valid  = 1'b0;
  logic        win_ready  = 1'b0;
  logic        pix_ready, mem_en, mem_rw, mem_wdata;
  logic [4:0]  mem_col, mem_row, mem_rdata;
  logic        win_valid, win_last, busy, done;
  logic [24:0] win_data;
  logic [4:0]  win_col, win_row;
`ifdef GRAPH_WIN_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic        start_scan4 = 1'b0;
  logic        win_ready4  = 1'b0;
  logic        pix_ready4, mem_en4, mem_rw4, mem_wdata4;
  logic [4:0]  mem_col4, mem_row4, mem_rdata4;
  logic        win_valid4, win_last4, busy4, done4;
  logic [24:0] win_data4;
  logic [4:0]  win_col4, win_row4;

  int n_checks = 0;
  int n_fails  = 0;

  graph_window_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef GRAPH_WIN_ABORT_EN
    .abort      (abort),
`endif
    .start_load (start_load),
    .start_scan (start_scan),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .mem_en     (mem_en),
    .mem_rw     (mem_rw),
    .mem_wdata  (mem_wdata),
    .mem_col    (mem_col),
    .mem_row    (mem_row),
    .mem_rdata  (mem_rdata),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_col    (win_col),
    .win_row    (win_row),
    .win_last   (win_last),
    .busy       (busy),
    .done       (done)
  );

  graph_window_ctrl #(.STRIDE(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef GRAPH_WIN_ABORT_EN
    .abort      (abort),
`endif
    .start_load (1'b0),
    .start_scan (start_scan4),
    .pix_data   (1'b0),
    .pix_valid  (1'b0),
    .pix_ready  (pix_ready4),
    .mem_en     (mem_en4),
    .mem_rw     (mem_rw4),
    .mem_wdata  (mem_wdata4),
    .mem_col    (mem_col4),
    .mem_row    (mem_row4),
    .mem_rdata  (mem_rdata4),
    .win_valid  (win_valid4),
    .win_ready  (win_ready4),
    .win_data   (win_data4),
    .win_col    (win_col4),
    .win_row    (win_row4),
    .win_last   (win_last4),
    .busy       (busy4),
    .done       (done4)
  );

  // Image memory behind the STRIDE=1 instance: bit write, 5-bit registered read.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (!mem_rw) begin
        mem[mem_col][mem_row] <= mem_wdata;
      end else begin
        for (int j = 0; j < 5; j++) mem_rdata[j] <= mem[mem_col][(int'(mem_row) + j) % 32];
      end
    end
  end

  // Read-only preloaded memory behind the STRIDE=4 instance.
  logic [31:0] mem4 [32];
  always @(posedge clk) begin
    if (mem_en4 && mem_rw4) begin
      for (int j = 0; j < 5; j++) mem_rdata4[j] <= mem4[mem_col4][(int'(mem_row4) + j) % 32];
    end
  end

  // Expected window for the checkerboard-like image at origin (c0, r0).
  function automatic logic [24:0] exp_win(input int c0, input int r0);
    logic [24:0] w;
    w = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 5; j++)
        w[5*k+j] = (((c0 + k + r0 + j) % 2) == 1);
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pix_ready, win_valid, win_last} !== 5'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {busy, done, pix_ready, win_valid, win_last});
    end
    n_checks++;
    if ({mem_en, mem_rw, mem_wdata, mem_col, mem_row} !== 13'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_mem_pins: got %h, expected 0", {mem_en, mem_rw, mem_wdata, mem_col, mem_row});
    end
    n_checks++;
    if ({win_data, win_col, win_row} !== 35'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_window: got %h, expected 0", {win_data, win_col, win_row});
    end
    n_checks++;
    if ({busy4, done4, pix_ready4, mem_en4, mem_rw4, mem_wdata4, win_valid4, win_last4} !== 8'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_dut4: got %b, expected 0", {busy4, done4, pix_ready4, mem_en4, mem_rw4, mem_wdata4, win_valid4, win_last4});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_release_idle: busy got %b, expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    int ready_cnt, done_n, rw_bad, addr_bad, bits_bad;
    ready_cnt = 0; done_n = 0; rw_bad = 0; addr_bad = 0; bits_bad = 0;
    start_load = 1'b1;
    pix_valid  = 1'b0;
    @(posedge clk); #1;
    start_load = 1'b0;
    for (int n = 1; n <= 1100 && done_n == 0; n++) begin
      int i;
      i = n - 1;
      pix_valid = 1'b1;
      pix_data  = i[5] ^ i[0];
      @(negedge clk);
      if (pix_ready) ready_cnt++;
      if (mem_rw) rw_bad++;
      if (mem_en && ({mem_col, mem_row} != 10'(i))) addr_bad++;
      if (done) done_n = n;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 32; r++)
        if (mem[c][r] !== (((c + r) % 2) == 1)) bits_bad++;
    n_checks++;
    if (ready_cnt != 1024) begin
      n_fails++;
      $display("[TB] FAIL load_ready_cycles: got %0d, expected 1024", ready_cnt);
    end
    n_checks++;
    if (done_n != 1025) begin
      n_fails++;
      $display("[TB] FAIL load_done_cycle: got %0d, expected 1025", done_n);
    end
    n_checks++;
    if (rw_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL load_rw_low: got %0d read cycles, expected 0", rw_bad);
    end
    n_checks++;
    if (addr_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL load_address: got %0d bad addresses, expected 0", addr_bad);
    end
    n_checks++;
    if (bits_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL load_image: got %0d wrong bits, expected 0", bits_bad);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL load_back_idle: busy,done got %b, expected 00", {busy, done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_priority();
    int ready_cnt, done_n, addr_bad;
    ready_cnt = 0; done_n = 0; addr_bad = 0;
    pix_valid  = 1'b0;
    start_load = 1'b1;
    start_scan = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    start_scan = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pix_ready, mem_en} !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL both_starts_load: pix_ready,mem_en got %b, expected 10", {pix_ready, mem_en});
    end
    @(posedge clk); #1;
    start_scan = 1'b1;
    @(posedge clk); #1;
    start_scan = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pix_ready, mem_rw, win_valid} !== 3'b100) begin
      n_fails++;
      $display("[TB] FAIL scan_ignored_in_load: got %b, expected 100", {pix_ready, mem_rw, win_valid});
    end
    @(posedge clk); #1;
    for (int n = 1; n <= 1100 && done_n == 0; n++) begin
      int i;
      i = n - 1;
      pix_valid = 1'b1;
      pix_data  = i[5] ^ i[0];
      @(negedge clk);
      if (pix_ready) ready_cnt++;
      if (mem_en && ({mem_col, mem_row} != 10'(i))) addr_bad++;
      if (done) done_n = n;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    n_checks++;
    if (done_n != 1025 || ready_cnt != 1024) begin
      n_fails++;
      $display("[TB] FAIL held_load_done: done cycle %0d ready %0d, expected 1025 1024", done_n, ready_cnt);
    end
    n_checks++;
    if (addr_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL held_load_index: got %0d bad addresses, expected 0", addr_bad);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL priority_back_idle: busy got %b, expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_scan_stride1();
    int hs, last_cnt, done_cnt, first_valid, data_bad, org_bad, en_bad;
    int stall, stall_bad, stall_n, accept_n, exp_c, exp_r;
    logic [24:0] w0_data, w1_data, held_data;
    logic [9:0]  w0_org, w1_org, held_org, last_org;
    hs = 0; last_cnt = 0; done_cnt = 0; first_valid = 0; data_bad = 0; org_bad = 0;
    en_bad = 0; stall = 0; stall_bad = 0; stall_n = 0; accept_n = 0;
    w0_data = '0; w1_data = '0; held_data = '0; w0_org = '1; w1_org = '1; held_org = '0; last_org = '0;
    start_scan = 1'b1;
    win_ready  = 1'b1;
    @(posedge clk); #1;
    start_scan = 1'b0;
    for (int n = 1; n <= 8000 && done_cnt == 0; n++) begin
      win_ready = !(hs == 2 && stall < 10);
      @(negedge clk);
      if (done) done_cnt++;
      if (win_valid) begin
        if (first_valid == 0) first_valid = n;
        if (mem_en) en_bad++;
        if (!win_ready) begin
          if (stall == 0) begin
            held_data = win_data;
            held_org  = {win_col, win_row};
            stall_n   = n;
          end else if (win_data !== held_data || {win_col, win_row} !== held_org) begin
            stall_bad++;
          end
          stall++;
        end else begin
          exp_c = hs % 28;
          exp_r = hs / 28;
          if ({win_col, win_row} !== {5'(exp_c), 5'(exp_r)}) org_bad++;
          if (win_data !== exp_win(exp_c, exp_r)) data_bad++;
          if (hs == 0) begin w0_data = win_data; w0_org = {win_col, win_row}; end
          if (hs == 1) begin w1_data = win_data; w1_org = {win_col, win_row}; end
          if (hs == 2) accept_n = n;
          if (win_last) begin last_cnt++; last_org = {win_col, win_row}; end
          hs++;
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (first_valid != 7) begin
      n_fails++;
      $display("[TB] FAIL first_valid_latency: got cycle %0d, expected 7", first_valid);
    end
    n_checks++;
    if (w0_org !== 10'd0 || w0_data !== 25'h0AAAAAA) begin
      n_fails++;
      $display("[TB] FAIL window0: origin %h data %h, expected 000 0aaaaaa", w0_org, w0_data);
    end
    n_checks++;
    if (w1_org !== {5'd1, 5'd0} || w1_data !== 25'h1555555) begin
      n_fails++;
      $display("[TB] FAIL window1: origin %h data %h, expected 020 1555555", w1_org, w1_data);
    end
    n_checks++;
    if (stall_bad != 0 || held_data !== 25'h0AAAAAA || held_org !== {5'd2, 5'd0}) begin
      n_fails++;
      $display("[TB] FAIL stall_stable: changes %0d data %h origin %h, expected 0 0aaaaaa 040", stall_bad, held_data, held_org);
    end
    n_checks++;
    if (accept_n - stall_n != 10) begin
      n_fails++;
      $display("[TB] FAIL stall_accept: got %0d cycles, expected 10", accept_n - stall_n);
    end
    n_checks++;
    if (en_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL out_mem_en: got %0d enabled cycles, expected 0", en_bad);
    end
    n_checks++;
    if (hs != 784) begin
      n_fails++;
      $display("[TB] FAIL stride1_count: got %0d handshakes, expected 784", hs);
    end
    n_checks++;
    if (org_bad != 0 || data_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL stride1_windows: bad origins %0d bad data %0d, expected 0 0", org_bad, data_bad);
    end
    n_checks++;
    if (last_cnt != 1 || last_org !== {5'd27, 5'd27}) begin
      n_fails++;
      $display("[TB] FAIL stride1_last: count %0d origin %h, expected 1 %h", last_cnt, last_org, {5'd27, 5'd27});
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fails++;
      $display("[TB] FAIL stride1_done: got %0d pulses, expected 1", done_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, win_valid} !== 3'b000) begin
      n_fails++;
      $display("[TB] FAIL stride1_back_idle: got %b, expected 000", {busy, done, win_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int hs, first_valid;
    logic [24:0] fdata;
    logic [9:0]  forg;
    hs = 0; first_valid = 0; fdata = '0; forg = '1;
    start_scan = 1'b1;
    win_ready  = 1'b1;
    @(posedge clk); #1;
    start_scan = 1'b0;
    for (int n = 1; n <= 2000 && hs < 100; n++) begin
      @(negedge clk);
      if (win_valid && win_ready) hs++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (hs != 100 || busy !== 1'b1 || mem_en !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL reach_window_100: hs %0d busy %b mem_en %b, expected 100 1 1", hs, busy, mem_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pix_ready, mem_en, mem_rw, mem_wdata, win_valid, win_last} !== 8'b0) begin
      n_fails++;
      $display("[TB] FAIL async_reset_ctrl: got %b, expected 0", {busy, done, pix_ready, mem_en, mem_rw, mem_wdata, win_valid, win_last});
    end
    n_checks++;
    if ({mem_col, mem_row, win_col, win_row, win_data} !== 45'b0) begin
      n_fails++;
      $display("[TB] FAIL async_reset_data: got %h, expected 0", {mem_col, mem_row, win_col, win_row, win_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_scan = 1'b1;
    @(posedge clk); #1;
    start_scan = 1'b0;
    for (int n = 1; n <= 20 && first_valid == 0; n++) begin
      @(negedge clk);
      if (win_valid) begin
        first_valid = n;
        fdata = win_data;
        forg  = {win_col, win_row};
      end
      @(posedge clk); #1;
    end
    win_ready = 1'b0;
    n_checks++;
    if (first_valid != 7 || forg !== 10'd0 || fdata !== 25'h0AAAAAA) begin
      n_fails++;
      $display("[TB] FAIL restart_after_reset: cycle %0d origin %h data %h, expected 7 000 0aaaaaa", first_valid, forg, fdata);
    end
  endtask

  task automatic test_scan_stride4();
    int hs, last_cnt, done_cnt, org_bad, data_bad, exp_c, exp_r;
    logic [9:0] last_org;
    hs = 0; last_cnt = 0; done_cnt = 0; org_bad = 0; data_bad = 0; last_org = '0;
    start_scan4 = 1'b1;
    win_ready4  = 1'b1;
    @(posedge clk); #1;
    start_scan4 = 1'b0;
    for (int n = 1; n <= 1000 && done_cnt == 0; n++) begin
      @(negedge clk);
      if (done4) done_cnt++;
      if (win_valid4 && win_ready4) begin
        exp_c = (hs % 7) * 4;
        exp_r = (hs / 7) * 4;
        if ({win_col4, win_row4} !== {5'(exp_c), 5'(exp_r)}) org_bad++;
        if (win_data4 !== exp_win(exp_c, exp_r)) data_bad++;
        if (win_last4) begin last_cnt++; last_org = {win_col4, win_row4}; end
        hs++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (hs != 49) begin
      n_fails++;
      $display("[TB] FAIL stride4_count: got %0d handshakes, expected 49", hs);
    end
    n_checks++;
    if (org_bad != 0 || data_bad != 0) begin
      n_fails++;
      $display("[TB] FAIL stride4_windows: bad origins %0d bad data %0d, expected 0 0", org_bad, data_bad);
    end
    n_checks++;
    if (last_cnt != 1 || last_org !== {5'd24, 5'd24}) begin
      n_fails++;
      $display("[TB] FAIL stride4_last: count %0d origin %h, expected 1 %h", last_cnt, last_org, {5'd24, 5'd24});
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fails++;
      $display("[TB] FAIL stride4_done: got %0d pulses, expected 1", done_cnt);
    end
  endtask

  initial begin
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 32; r++)
        mem4[c][r] = (((c + r) % 2) == 1);
    test_reset();
    test_load();
    test_start_priority();
    test_scan_stride1();
    test_reset_mid_scan();
    test_scan_stride4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
